// File: rtl/window_3x3_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_3x3_gen_pkg
// Purpose  : Shared constants for the 3x3 window generator. Covers the pixel
//            width, the tap field offsets inside the packed window word and
//            the sequencer state encoding.
// Revision : 1.0  initial release
// ============================================================================
package window_3x3_gen_pkg;

    // RGB444 pixel; the window layout below is built around this width
    localparam int PIX_W = 12;
    localparam int WIN_W = 9 * PIX_W;

    // Tap positions inside the 108-bit color_data word
    localparam int CENTRE_LSB    = 96;
    localparam int LEFT_LSB      = 84;
    localparam int RIGHT_LSB     = 72;
    localparam int UP_LSB        = 60;
    localparam int DOWN_LSB      = 48;
    localparam int UPLEFT_LSB    = 36;
    localparam int UPRIGHT_LSB   = 24;
    localparam int DOWNLEFT_LSB  = 12;
    localparam int DOWNRIGHT_LSB = 0;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage : window_3x3_gen_pkg
`default_nettype wire

// File: rtl/window_3x3_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : window_3x3_gen_line_buffer
// Purpose  : One image line of pixel storage. A single shared address serves
//            one read and one optional write per enabled cycle. The read is
//            registered and returns the contents from before the write.
// Revision : 1.0  initial release
// ============================================================================
module window_3x3_gen_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = window_3x3_gen_pkg::PIX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Registered read of the old contents; cleared by reset so the window
    // output reads as zero straight after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (i_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_en && i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : window_3x3_gen_line_buffer
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : window_3x3_gen
// Purpose  : Builds an edge-clamped 3x3 neighbourhood for every pixel of a
//            raster RGB444 stream. One window is produced per pixel. The
//            window for centre k appears the cycle after input k+IMG_W+1 is
//            accepted, and a flush tail drains the last IMG_W+1 windows.
// Revision : 1.0  initial release
// ============================================================================
module window_3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic [9*PIX_W-1:0]   color_data,
    output logic                 win_valid,
    output logic                 win_sof
);
    import window_3x3_gen_pkg::*;

    localparam int c_n_pix = IMG_W * IMG_H;
    localparam int c_idx_w = $clog2(c_n_pix + IMG_W + 1);
    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_y_w   = $clog2(IMG_H);

    localparam logic [c_idx_w-1:0] c_last_in    = c_idx_w'(c_n_pix - 1);
    localparam logic [c_idx_w-1:0] c_last_flush = c_idx_w'(c_n_pix + IMG_W);
    localparam logic [c_idx_w-1:0] c_first_emit = c_idx_w'(IMG_W + 1);
    localparam logic [c_col_w-1:0] c_col_last   = c_col_w'(IMG_W - 1);
    localparam logic [c_y_w-1:0]   c_row_last   = c_y_w'(IMG_H - 1);

    // Sequencer and input-side position of the next (real or virtual) pixel
    logic [1:0]         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [c_col_w-1:0] r_col;
    logic               r_par;      // parity of the input row
    logic               r_par_q;    // parity of the row behind the line buffer outputs

    // Centre position of the next window to emit, and the clamp flags of the
    // window on display
    logic [c_col_w-1:0] r_ocx;
    logic [c_y_w-1:0]   r_ocy;
    logic               r_fl, r_fr, r_ft, r_fb;
    logic               r_win_valid, r_win_sof;

    // Right column comes from the line buffers and r_pix; centre and left are
    // shifted copies of it
    logic [PIX_W-1:0]   r_pix;
    logic [PIX_W-1:0]   r_ct, r_cm, r_cb;
    logic [PIX_W-1:0]   r_lt, r_lm, r_lb;

    logic               w_adv;
    logic [c_idx_w-1:0] w_j;
    logic [c_col_w-1:0] w_col;
    logic               w_par;
    logic [1:0]         w_state_nxt;
    logic               w_emit;
    logic               w_col_wrap;
    logic [PIX_W-1:0]   w_lb_rd [2];
    logic [PIX_W-1:0]   w_rt, w_rm, w_rb;

    // Decide whether this cycle consumes a pixel slot and which index it is
    always_comb begin
        w_adv       = 1'b0;
        w_j         = r_idx;
        w_col       = r_col;
        w_par       = r_par;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    w_adv       = 1'b1;
                    w_j         = '0;
                    w_col       = '0;
                    w_par       = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    w_adv = 1'b1;
                    if (in_sof) begin
                        // New frame starts here; the old one is abandoned
                        w_j   = '0;
                        w_col = '0;
                        w_par = 1'b0;
                    end else if (r_idx == c_last_in) begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                w_adv = 1'b1;
                if (r_idx == c_last_flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_emit     = w_adv && (w_j >= c_first_emit);
    assign w_col_wrap = (w_col == c_col_last);
    assign in_ready   = (r_state != ST_FLUSH);

    // Two line buffers alternate by row parity: the buffer matching the
    // current row holds row-2 (read then overwritten), the other holds row-1
    for (genvar gi = 0; gi < 2; gi++) begin : g_lb
        window_3x3_gen_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_line_buffer (
            .clk       (clk),
            .reset     (reset),
            .i_en      (w_adv),
            .i_wr_en   (w_par == 1'(gi)),
            .i_addr    (w_col),
            .i_wr_data (pix_in),
            .o_rd_data (w_lb_rd[gi])
        );
    end

    assign w_rt = r_par_q ? w_lb_rd[1] : w_lb_rd[0];
    assign w_rm = r_par_q ? w_lb_rd[0] : w_lb_rd[1];
    assign w_rb = r_pix;

    // Sequencer, input position and output window bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_col       <= '0;
            r_par       <= 1'b0;
            r_par_q     <= 1'b0;
            r_ocx       <= '0;
            r_ocy       <= '0;
            r_fl        <= 1'b0;
            r_fr        <= 1'b0;
            r_ft        <= 1'b0;
            r_fb        <= 1'b0;
            r_win_valid <= 1'b0;
            r_win_sof   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_valid <= 1'b0;
            r_win_sof   <= 1'b0;
            if (w_adv) begin
                r_idx   <= w_j + 1'b1;
                r_col   <= w_col_wrap ? '0 : w_col + 1'b1;
                r_par   <= w_col_wrap ? ~w_par : w_par;
                r_par_q <= w_par;
                if (w_j == '0) begin
                    r_ocx <= '0;
                    r_ocy <= '0;
                end else if (w_emit) begin
                    r_win_valid <= 1'b1;
                    r_win_sof   <= (r_ocx == '0) && (r_ocy == '0);
                    r_fl        <= (r_ocx == '0);
                    r_fr        <= (r_ocx == c_col_last);
                    r_ft        <= (r_ocy == '0);
                    r_fb        <= (r_ocy == c_row_last);
                    if (r_ocx == c_col_last) begin
                        r_ocx <= '0;
                        if (r_ocy != c_row_last) begin
                            r_ocy <= r_ocy + 1'b1;
                        end
                    end else begin
                        r_ocx <= r_ocx + 1'b1;
                    end
                end
            end
        end
    end

    // Column shift registers: right column moves to centre, centre to left
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix <= '0;
            r_ct  <= '0;
            r_cm  <= '0;
            r_cb  <= '0;
            r_lt  <= '0;
            r_lm  <= '0;
            r_lb  <= '0;
        end else if (w_adv) begin
            r_pix <= pix_in;
            r_ct  <= w_rt;
            r_cm  <= w_rm;
            r_cb  <= w_rb;
            r_lt  <= r_ct;
            r_lm  <= r_cm;
            r_lb  <= r_cb;
        end
    end

    // Edge clamp: any tap outside the image takes the centre pixel
    always_comb begin
        color_data = '0;
        color_data[CENTRE_LSB    +: PIX_W] = r_cm;
        color_data[LEFT_LSB      +: PIX_W] = r_fl          ? r_cm : r_lm;
        color_data[RIGHT_LSB     +: PIX_W] = r_fr          ? r_cm : w_rm;
        color_data[UP_LSB        +: PIX_W] = r_ft          ? r_cm : r_ct;
        color_data[DOWN_LSB      +: PIX_W] = r_fb          ? r_cm : r_cb;
        color_data[UPLEFT_LSB    +: PIX_W] = (r_fl || r_ft) ? r_cm : r_lt;
        color_data[UPRIGHT_LSB   +: PIX_W] = (r_fr || r_ft) ? r_cm : w_rt;
        color_data[DOWNLEFT_LSB  +: PIX_W] = (r_fl || r_fb) ? r_cm : r_lb;
        color_data[DOWNRIGHT_LSB +: PIX_W] = (r_fr || r_fb) ? r_cm : w_rb;
    end

    assign win_valid = r_win_valid;
    assign win_sof   = r_win_sof;

endmodule : window_3x3_gen
`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_3x3_gen
// Purpose  : Self-checking bench for window_3x3_gen on a 4x3 image, using
//            flat, ramp and random frames with random input bubbles, plus
//            mid-frame reset and mid-frame restart.
// Revision : 1.0  initial release
// ============================================================================
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  pix_in;
    logic         in_valid;
    logic         in_sof;
    logic         in_ready;
    logic [107:0] color_data;
    logic         win_valid;
    logic         win_sof;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0]  frm     [N];
    logic [107:0] got_win [N];

    window_3x3_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .color_data (color_data),
        .win_valid  (win_valid),
        .win_sof    (win_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [107:0] got, input logic [107:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pixel at offset (dx,dy) from centre k, or the centre when off-image
    function automatic logic [11:0] tap(input int k, input int dx, input int dy);
        int x;
        int y;
        x = (k % W) + dx;
        y = (k / W) + dy;
        if (x < 0 || x >= W || y < 0 || y >= H) return frm[k];
        return frm[y * W + x];
    endfunction

    function automatic logic [107:0] ref_win(input int k);
        return {tap(k, 0, 0), tap(k, -1, 0), tap(k, 1, 0), tap(k, 0, -1), tap(k, 0, 1),
                tap(k, -1, -1), tap(k, 1, -1), tap(k, -1, 1), tap(k, 1, 1)};
    endfunction

    // Expect window k right after its slot (accepted or flush) was taken
    task automatic expect_window(input int k);
        check("win_valid", 108'(win_valid), 108'(1));
        check($sformatf("win%0d", k), color_data, ref_win(k));
        check($sformatf("win_sof%0d", k), 108'(win_sof), 108'(k == 0));
        got_win[k] = color_data;
    endtask

    // Send pixels 0..stop_after-1 of frm; a full frame is followed by flush
    task automatic drive_frame(input int bubble_pct, input int stop_after);
        int j;
        j = 0;
        while (j < stop_after) begin
            bit v;
            v = (int'($urandom_range(99)) >= bubble_pct);
            in_valid = v;
            in_sof   = v && (j == 0);
            pix_in   = v ? frm[j] : 12'($urandom);
            check("ready_run", 108'(in_ready), 108'(1));
            @(posedge clk);
            #1;
            if (v) begin
                if (j >= W + 1) expect_window(j - W - 1);
                else check("early_valid", 108'(win_valid), 108'(0));
                j++;
            end else begin
                check("bubble_valid", 108'(win_valid), 108'(0));
            end
        end
        if (stop_after == N) begin
            for (int f = 0; f <= W; f++) begin
                in_valid = 1'b1;
                in_sof   = 1'($urandom_range(1));
                pix_in   = 12'($urandom);
                check("ready_flush", 108'(in_ready), 108'(0));
                @(posedge clk);
                #1;
                expect_window(N + f - W - 1);
            end
            in_valid = 1'b0;
            in_sof   = 1'b0;
            check("ready_idle", 108'(in_ready), 108'(1));
            @(posedge clk);
            #1;
            check("idle_valid", 108'(win_valid), 108'(0));
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle_junk(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            pix_in   = 12'($urandom);
            @(posedge clk);
            #1;
            check("idle_drop", 108'(win_valid), 108'(0));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        pix_in   = '0;
        @(posedge clk);
        #1;
        check("rst_color", color_data, 108'(0));
        check("rst_valid", 108'(win_valid), 108'(0));
        check("rst_sof", 108'(win_sof), 108'(0));
        check("rst_ready", 108'(in_ready), 108'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Non-sof pixels in IDLE are dropped
        idle_junk(3);

        // Flat frame
        for (int i = 0; i < N; i++) frm[i] = 12'hABC;
        drive_frame(0, N);
        check("flat_first", got_win[0], {9{12'hABC}});

        // Ramp frame with hand-derived edge windows
        for (int i = 0; i < N; i++) frm[i] = 12'(i);
        drive_frame(0, N);
        check("ramp_c11", got_win[5], {12'd5, 12'd4, 12'd6, 12'd1, 12'd9, 12'd0, 12'd2, 12'd8, 12'd10});
        check("ramp_c00", got_win[0], {12'd0, 12'd0, 12'd1, 12'd0, 12'd4, 12'd0, 12'd0, 12'd0, 12'd5});
        check("ramp_c32", got_win[11], {12'd11, 12'd10, 12'd11, 12'd7, 12'd11, 12'd6, 12'd11, 12'd11, 12'd11});
        check("ramp_c30", got_win[3], {12'd3, 12'd2, 12'd3, 12'd3, 12'd7, 12'd3, 12'd3, 12'd6, 12'd3});

        // Ramp with bubbles, then random frames with bubbles
        drive_frame(40, N);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
            drive_frame(30, N);
        end

        // Reset after pixel 6, then a full ramp
        for (int i = 0; i < N; i++) frm[i] = 12'(i);
        drive_frame(0, 7);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("mid_rst_color", color_data, 108'(0));
        check("mid_rst_valid", 108'(win_valid), 108'(0));
        check("mid_rst_ready", 108'(in_ready), 108'(1));
        drive_frame(20, N);

        // sof on pixel 7 restarts the frame
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        drive_frame(0, 7);
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        drive_frame(20, N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_window_3x3_gen
`default_nettype wire

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Upstream neighbour of the 3x3 filter stages, such as the averaging filter.
- Takes a raster-order RGB444 pixel stream, keeps two line buffers and builds a 3x3 neighbourhood per pixel.
- Emits each neighbourhood as the 108-bit packed `color_data` word the filter stages consume: one window per image pixel, raster order, edge-clamped.

Parameters:
- IMG_W, 640, pixels per line (>=2)
- IMG_H, 480, lines per frame (>=2)
- PIX_W, 12, pixel width (RGB444; fixed at 12, the window layout depends on it)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- pix_in  in  12  input pixel, R[11:8] G[7:4] B[3:0]
- in_valid  in  1  pix_in valid
- in_sof  in  1  marks pixel (0,0); qualified by in_valid
- in_ready  out  1  block accepts pixel when in_valid & in_ready
- color_data  out  108  window: [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] upleft, [35:24] upright, [23:12] downleft, [11:0] downright
- win_valid  out  1  color_data valid, single-cycle per window
- win_sof  out  1  high with win_valid for centre (0,0)

Behaviour:
- Reset (reset==0 at clk edge):
  - Outputs: color_data=0, win_valid=0, win_sof=0, in_ready=1.
  - Counters and FSM clear; line buffer contents don't-care.
  - Reset mid-frame discards the partial frame.
- FSM states:
  - IDLE: in_ready=1; waits for an accepted pixel with in_sof=1; pixels without sof are dropped. Accepting sof sets in_idx=1 and goes to RUN.
  - RUN: in_ready=1; each accepted pixel increments linear input index in_idx. After accepting index IMG_W*IMG_H-1, go to FLUSH.
  - FLUSH: in_ready=0 for exactly IMG_W+1 cycles. Each cycle acts as one virtual accepted pixel, which emits one window. Then go to IDLE.
- Emission rule: the window for linear centre index k = cy*IMG_W+cx is emitted on the cycle after accepting input index k+IMG_W+1 (or the equivalent flush cycle). Latency is a fixed IMG_W+1 accepted pixels, plus one register stage.
- Windows per frame: exactly IMG_W*IMG_H.
- No output backpressure: win_valid is a one-cycle pulse.
- Input bubbles (in_valid=0) stall everything: no window emitted, registers hold.
- Edge clamp: any tap outside the image (cx-1<0, cx+1>IMG_W-1, cy-1<0, cy+1>IMG_H-1) carries the centre pixel value, not zero. Corner taps are clamped if either coordinate is out of range.
- Line-end wrap: taps never wrap into the adjacent line; the clamp overrides.
- in_sof while in RUN:
  - Abandons the current frame; no further windows from it.
  - The sof pixel becomes index 0 of a new frame.
  - Treated as an accepted pixel, same cycle.
- in_sof while in FLUSH: ignored (in_ready=0).
- Centre coordinate counters (cx,cy) wrap cx at IMG_W-1 and advance cy; cy never exceeds IMG_H-1 within a frame.
- Line buffers: 2 x IMG_W x 12 bits. One read and one write per accepted or flush cycle, same address; read-before-write.

Decomposition:
- Shared package:
  - PIX_W=12.
  - Window field offsets (CENTRE_LSB=96, LEFT_LSB=84, RIGHT_LSB=72, UP_LSB=60, DOWN_LSB=48, UPLEFT_LSB=36, UPRIGHT_LSB=24, DOWNLEFT_LSB=12, DOWNRIGHT_LSB=0).
  - FSM state encoding (IDLE, RUN, FLUSH).
- Sub-module line_buffer:
  - Parameterised depth IMG_W, width PIX_W, registered read.
  - Instantiated twice.
- Clamp muxing and the 3x3 shift registers stay in window_3x3_gen.

Test Plan (IMG_W=4, IMG_H=3 unless stated):
- Flat frame: 12 pixels 12'hABC with sof on the first -> 12 win_valid pulses, each color_data={9{12'hABC}}. First pulse on the cycle after accepting pixel 5. win_sof on the first pulse only.
- Ramp frame, pixel = linear index -> centre (1,1): centre=5, left=4, right=6, up=1, down=9, upleft=0, upright=2, downleft=8, downright=10.
- Ramp edges:
  - Centre (0,0): right=1, down=4, downright=5, all other taps 0.
  - Centre (3,2): centre=11, left=10, up=7, upleft=6, others 11.
  - Centre (3,0): no wrap into line 1; right=upright=3.
- Flush: in_valid held high after the last pixel -> in_ready=0 for exactly 5 cycles, 5 windows emitted, then in_ready=1 in IDLE. Pixels offered during flush are not accepted.
- Bubbles: in_valid low on random cycles during the ramp -> identical window contents and order to the no-bubble run; win_valid gaps track the bubbles.
- Reset/restart:
  - reset=0 for one cycle after pixel 6 -> next cycle color_data=0, win_valid=0, in_ready=1. A full new ramp frame then produces correct windows.
  - Separately, sof asserted at pixel 7 of a frame -> windows restart at centre (0,0) with win_sof.
